// File: rtl/d_bram_dp_if.sv
// Request/response bundle for d_bram_dp: two independent byte-writable
// request ports (A and B), their read data, and the zero-fill busy flag.
interface d_bram_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    localparam int NB = DATA_W / 32'sd8;

    logic              ena;
    logic [NB-1:0]     wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    logic              enb;
    logic [NB-1:0]     web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] doutb;

    logic              init_busy;

    modport master (
        output ena, wea, addra, dina,
        output enb, web, addrb, dinb,
        input  douta, doutb, init_busy
    );

    modport slave (
        input  ena, wea, addra, dina,
        input  enb, web, addrb, dinb,
        output douta, doutb, init_busy
    );
endinterface

// File: rtl/d_bram_dp.sv
// True-dual-port byte-writable data RAM on a single clock.
// Port A has lane priority over port B on same-address writes; a read on
// one port always sees the other port's pre-write word. After reset an
// optional sweep zeroes every word while init_busy is high and requests
// are ignored. Read latency is 1 or 2 cycles, same-port read-during-write
// returns either the old word or the merged word.
module d_bram_dp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int RD_LAT       = 1,
    parameter int WR_MODE      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic        clka,
    input  logic        rsta_n,
    d_bram_dp_if.slave  bus
);
    localparam int LANE_W = 32'sd8;
    localparam int NB     = DATA_W / LANE_W;
    localparam int DEPTH  = 32'sd1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RST != 32'sd0) ? ST_CLEAR : ST_READY;
    localparam logic   BUSY_RST  = (CLEAR_ON_RST != 32'sd0) ? 1'b1 : 1'b0;

    // Replace the lanes selected by we with new data, keep the rest.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     we
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                res[LANE_W*i +: LANE_W] = new_w[LANE_W*i +: LANE_W];
            end else begin
                res[LANE_W*i +: LANE_W] = old_w[LANE_W*i +: LANE_W];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              init_busy_q, init_busy_d;
    logic              clr_we_s;

    logic              ready_s;
    logic              wr_a_s, wr_b_s;
    logic              rd_en_a_s, rd_en_b_s;
    logic [DATA_W-1:0] rd_old_a_s, rd_old_b_s;
    logic [DATA_W-1:0] rd_a_s, rd_b_s;

    logic [DATA_W-1:0] douta_q, doutb_q;

    // FSM state register, sweep counter and registered busy flag
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            init_busy_q <= BUSY_RST;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Next state: sweep one word per edge, leave CLEAR after the last word
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we_s  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we_s = 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_READY: begin
                state_d   = ST_READY;
                clr_cnt_d = '0;
            end
            default: begin
                state_d   = RST_STATE;
                clr_cnt_d = '0;
            end
        endcase
        init_busy_d = (state_d == ST_CLEAR);
    end

    // Request qualification and read-word selection for both ports
    always_comb begin
        ready_s    = (state_q == ST_READY);
        rd_en_a_s  = ready_s & bus.ena;
        rd_en_b_s  = ready_s & bus.enb;
        wr_a_s     = rd_en_a_s & (|bus.wea);
        wr_b_s     = rd_en_b_s & (|bus.web);
        rd_old_a_s = mem_q[bus.addra];
        rd_old_b_s = mem_q[bus.addrb];
        if (WR_MODE == 32'sd1) begin
            rd_a_s = merge_lanes(rd_old_a_s, bus.dina, bus.wea);
            rd_b_s = merge_lanes(rd_old_b_s, bus.dinb, bus.web);
        end else begin
            rd_a_s = rd_old_a_s;
            rd_b_s = rd_old_b_s;
        end
    end

    // Array update: sweep clear, else per-lane writes with port A applied last so it wins shared lanes
    always_ff @(posedge clka) begin
        if (clr_we_s) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b_s && bus.web[i]) begin
                    mem_q[bus.addrb][LANE_W*i +: LANE_W] <= bus.dinb[LANE_W*i +: LANE_W];
                end
                if (wr_a_s && bus.wea[i]) begin
                    mem_q[bus.addra][LANE_W*i +: LANE_W] <= bus.dina[LANE_W*i +: LANE_W];
                end
            end
        end
    end

    generate
        if (RD_LAT == 32'sd2) begin : g_lat2
            logic [DATA_W-1:0] s1_a_q, s1_b_q;
            logic              v_a_q, v_b_q;

            // Two-stage read: capture on request, forward to output only behind a valid first stage
            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    s1_a_q  <= '0;
                    s1_b_q  <= '0;
                    v_a_q   <= 1'b0;
                    v_b_q   <= 1'b0;
                    douta_q <= '0;
                    doutb_q <= '0;
                end else begin
                    v_a_q <= rd_en_a_s;
                    v_b_q <= rd_en_b_s;
                    if (rd_en_a_s) begin
                        s1_a_q <= rd_a_s;
                    end
                    if (rd_en_b_s) begin
                        s1_b_q <= rd_b_s;
                    end
                    if (v_a_q) begin
                        douta_q <= s1_a_q;
                    end
                    if (v_b_q) begin
                        doutb_q <= s1_b_q;
                    end
                end
            end
        end else begin : g_lat1
            // Single-stage read: output loads on an accepted request and holds otherwise
            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    douta_q <= '0;
                    doutb_q <= '0;
                end else begin
                    if (rd_en_a_s) begin
                        douta_q <= rd_a_s;
                    end
                    if (rd_en_b_s) begin
                        doutb_q <= rd_b_s;
                    end
                end
            end
        end
    endgenerate

    assign bus.douta     = douta_q;
    assign bus.doutb     = doutb_q;
    assign bus.init_busy = init_busy_q;

endmodule
